// File: rtl/regfile_alu.sv
// regfile_alu -- datapath core of the 8-bit CPU.
//
// A 16-entry register file with two synchronous write ports and two
// combinational read ports, feeding a combinational ALU. Registers 14/15
// hold the program counter (low/high byte); the sequencer updates both in
// one cycle by using the two write ports together.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst_n                asynchronous active-low reset, clears every register
//   write0/waddr0/wdata0 write port 0 (ALU write-back path)
//   write1/waddr1/wdata1 write port 1; wins a same-address collision
//   raddr0 -> rdata0     read port 0, ALU operand A
//   raddr1 -> rdata1     read port 1, ALU operand B
//   alu_op               ALU function: ADD SUB AND OR NOT XOR SHL SHR
//   alu_result/alu_carry ALU result and carry/flag
//
// Configuration macro: REGFILE_ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero (writes ignored, reads 0)
//   undefined -> register 0 is an ordinary register
module regfile_alu #(
  parameter int WIDTH_WORD = 8,
  parameter int WIDTH_SEG  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write0,
  input  logic                  write1,
  input  logic [WIDTH_SEG-1:0]  waddr0,
  input  logic [WIDTH_WORD-1:0] wdata0,
  input  logic [WIDTH_SEG-1:0]  waddr1,
  input  logic [WIDTH_WORD-1:0] wdata1,
  input  logic [WIDTH_SEG-1:0]  raddr0,
  output logic [WIDTH_WORD-1:0] rdata0,
  input  logic [WIDTH_SEG-1:0]  raddr1,
  output logic [WIDTH_WORD-1:0] rdata1,
  input  logic [2:0]            alu_op,
  output logic [WIDTH_WORD-1:0] alu_result,
  output logic                  alu_carry
);

  localparam int DEPTH = 2 ** WIDTH_SEG;

  logic [WIDTH_WORD-1:0] regs_r [DEPTH];
  logic                  we0_s;
  logic                  we1_s;
  logic [WIDTH_WORD-1:0] a_s;
  logic [WIDTH_WORD-1:0] b_s;
  logic [WIDTH_WORD:0]   sum_s;
  logic [WIDTH_WORD:0]   diff_s;

  // Effective write enables; with the zero register, writes to r0 are dropped.
`ifdef REGFILE_ZERO_REG_EN
  assign we0_s = write0 && (waddr0 != {WIDTH_SEG{1'b0}});
  assign we1_s = write1 && (waddr1 != {WIDTH_SEG{1'b0}});
`else
  assign we0_s = write0;
  assign we1_s = write1;
`endif

  // Register file storage. Port 1 is assigned last so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH_WORD{1'b0}};
      end
    end else begin
      if (we0_s) begin
        regs_r[waddr0] <= wdata0;
      end
      if (we1_s) begin
        regs_r[waddr1] <= wdata1;
      end
    end
  end

  // Combinational read ports; no write-to-read bypass, so a same-cycle
  // write becomes visible only after the edge.
  always_comb begin
    rdata0 = regs_r[raddr0];
    rdata1 = regs_r[raddr1];
`ifdef REGFILE_ZERO_REG_EN
    if (raddr0 == {WIDTH_SEG{1'b0}}) begin
      rdata0 = {WIDTH_WORD{1'b0}};
    end else begin
      rdata0 = regs_r[raddr0];
    end
    if (raddr1 == {WIDTH_SEG{1'b0}}) begin
      rdata1 = {WIDTH_WORD{1'b0}};
    end else begin
      rdata1 = regs_r[raddr1];
    end
`endif
  end

  assign a_s    = rdata0;
  assign b_s    = rdata1;
  assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
  // Bit WIDTH_WORD of the widened difference is the borrow; carry is its inverse.
  assign diff_s = {1'b0, a_s} - {1'b0, b_s};

  // ALU function decode.
  always_comb begin
    alu_result = {WIDTH_WORD{1'b0}};
    alu_carry  = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_result = sum_s[WIDTH_WORD-1:0];
        alu_carry  = sum_s[WIDTH_WORD];
      end
      3'b001: begin
        alu_result = diff_s[WIDTH_WORD-1:0];
        alu_carry  = ~diff_s[WIDTH_WORD];
      end
      3'b010: begin
        alu_result = a_s & b_s;
        alu_carry  = 1'b0;
      end
      3'b011: begin
        alu_result = a_s | b_s;
        alu_carry  = 1'b0;
      end
      3'b100: begin
        alu_result = ~a_s;
        alu_carry  = 1'b0;
      end
      3'b101: begin
        alu_result = a_s ^ b_s;
        alu_carry  = 1'b0;
      end
      3'b110: begin
        alu_result = {a_s[WIDTH_WORD-2:0], 1'b0};
        alu_carry  = a_s[WIDTH_WORD-1];
      end
      3'b111: begin
        alu_result = {1'b0, a_s[WIDTH_WORD-1:1]};
        alu_carry  = a_s[0];
      end
      default: begin
        alu_result = {WIDTH_WORD{1'b0}};
        alu_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_alu.sv
// Directed testbench for regfile_alu with hand-computed expected values.
module tb_regfile_alu;

  logic       clk;
  logic       rst_n;
  logic       write0;
  logic       write1;
  logic [3:0] waddr0;
  logic [7:0] wdata0;
  logic [3:0] waddr1;
  logic [7:0] wdata1;
  logic [3:0] raddr0;
  logic [7:0] rdata0;
  logic [3:0] raddr1;
  logic [7:0] rdata1;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_carry;

  int checks_cnt;
  int errors_cnt;

  regfile_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write0     (write0),
    .write1     (write1),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .raddr0     (raddr0),
    .rdata0     (rdata0),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One write cycle: drive at negedge, commit at posedge, then idle the ports.
  task automatic wr(input logic e0, input logic [3:0] a0, input logic [7:0] d0,
                    input logic e1, input logic [3:0] a1, input logic [7:0] d1);
    @(negedge clk);
    write0 = e0; waddr0 = a0; wdata0 = d0;
    write1 = e1; waddr1 = a1; wdata1 = d1;
    @(posedge clk);
    #1;
    write0 = 1'b0;
    write1 = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1, input logic [2:0] op);
    raddr0 = a0; raddr1 = a1; alu_op = op;
    #1;
  endtask

  logic [2:0] ops_v [6];
  logic [7:0] res_v [6];
  logic       car_v [6];

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    write0 = 1'b0; write1 = 1'b0;
    waddr0 = 4'd0; wdata0 = 8'd0; waddr1 = 4'd0; wdata1 = 8'd0;
    raddr0 = 4'd0; raddr1 = 4'd0; alu_op = 3'b000;
    #12;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i), 3'b000);
      check($sformatf("reset_rd0_%0d", i), {8'h00, rdata0}, 16'h0000);
      check($sformatf("reset_rd1_%0d", i), {8'h00, rdata1}, 16'h0000);
    end
    check("reset_alu", {7'h00, alu_carry, alu_result}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Dual write then ADD
    wr(1'b1, 4'd1, 8'd8, 1'b1, 4'd3, 8'd5);
    rd(4'd3, 4'd1, 3'b000);
    check("add_8_5", {7'h00, alu_carry, alu_result}, 16'h000D);
    wr(1'b1, 4'd2, 8'd13, 1'b0, 4'd0, 8'd0);
    rd(4'd2, 4'd2, 3'b000);
    check("wb_reg2", {8'h00, rdata0}, 16'h000D);

    // Carry/borrow boundaries
    wr(1'b1, 4'd4, 8'hFF, 1'b1, 4'd5, 8'h01);
    rd(4'd4, 4'd5, 3'b000);
    check("add_ff_01", {7'h00, alu_carry, alu_result}, 16'h0100);
    rd(4'd3, 4'd1, 3'b001);
    check("sub_5_8", {7'h00, alu_carry, alu_result}, 16'h00FD);
    rd(4'd1, 4'd3, 3'b001);
    check("sub_8_5", {7'h00, alu_carry, alu_result}, 16'h0103);
    rd(4'd1, 4'd1, 3'b001);
    check("sub_eq", {7'h00, alu_carry, alu_result}, 16'h0100);

    // Collision: port 1 wins; no bypass during the write cycle
    wr(1'b1, 4'd6, 8'h11, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    write0 = 1'b1; waddr0 = 4'd6; wdata0 = 8'hAA;
    write1 = 1'b1; waddr1 = 4'd6; wdata1 = 8'h55;
    rd(4'd6, 4'd6, 3'b000);
    check("no_bypass", {8'h00, rdata0}, 16'h0011);
    @(posedge clk);
    #1;
    write0 = 1'b0; write1 = 1'b0;
    check("collision", {rdata1, rdata0}, 16'h5555);

    // Program counter pair
    wr(1'b1, 4'd14, 8'h0A, 1'b1, 4'd15, 8'h00);
    rd(4'd14, 4'd15, 3'b000);
    check("pc_0a", {rdata1, rdata0}, 16'h000A);
    wr(1'b1, 4'd14, 8'h0C, 1'b1, 4'd15, 8'h00);
    rd(4'd14, 4'd15, 3'b000);
    check("pc_0c", {rdata1, rdata0}, 16'h000C);
    wr(1'b1, 4'd14, 8'h34, 1'b1, 4'd15, 8'h12);
    rd(4'd14, 4'd15, 3'b000);
    check("pc_1234", {rdata1, rdata0}, 16'h1234);

    // Logic and shift ops, A=0xC3 B=0x0F
    wr(1'b1, 4'd7, 8'hC3, 1'b1, 4'd8, 8'h0F);
    ops_v = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    res_v = '{8'h03, 8'hCF, 8'h3C, 8'hCC, 8'h86, 8'h61};
    car_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      rd(4'd7, 4'd8, ops_v[k]);
      check($sformatf("op_%0d", ops_v[k]), {7'h00, alu_carry, alu_result}, {7'h00, car_v[k], res_v[k]});
    end
    // Shift carry-out zero cases with A=0x0F used as operand A
    rd(4'd8, 4'd7, 3'b110);
    check("shl_0f", {7'h00, alu_carry, alu_result}, 16'h001E);
    wr(1'b1, 4'd9, 8'h82, 1'b0, 4'd0, 8'd0);
    rd(4'd9, 4'd7, 3'b111);
    check("shr_82", {7'h00, alu_carry, alu_result}, 16'h0041);

    // Register 0
    wr(1'b1, 4'd0, 8'h55, 1'b0, 4'd0, 8'd0);
    rd(4'd0, 4'd0, 3'b000);
`ifdef REGFILE_ZERO_REG_EN
    check("reg0", {rdata1, rdata0}, 16'h0000);
`else
    check("reg0", {rdata1, rdata0}, 16'h5555);
`endif

    // Asynchronous reset mid-write discards the write
    wr(1'b1, 4'd5, 8'h7A, 1'b0, 4'd0, 8'd0);
    rd(4'd5, 4'd4, 3'b000);
    check("load_reg5", {rdata1, rdata0}, 16'hFF7A);
    @(negedge clk);
    write0 = 1'b1; waddr0 = 4'd5; wdata0 = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {rdata1, rdata0}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold", {8'h00, rdata0}, 16'h0000);
    @(negedge clk);
    write0 = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_discard", {8'h00, rdata0}, 16'h0000);
    wr(1'b1, 4'd5, 8'h44, 1'b0, 4'd0, 8'd0);
    rd(4'd5, 4'd5, 3'b000);
    check("post_rst_wr", {7'h00, alu_carry, alu_result}, 16'h0088);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
